// File: rtl/mult_div_unit.sv
// mult_div_unit: radix-2 sequential multiply/divide unit for the HI/LO registers.
// Signed operands are reduced to magnitudes at start, iterated unsigned for
// WIDTH cycles, then sign-corrected in a single FIX cycle before hi/lo are written.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              CntW     = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} stateT;

  stateT              state;
  logic [CntW-1:0]    iterCnt;
  logic               isDiv;     // latched op[1]
  logic               negRes;    // product / quotient must be negated
  logic               negRem;    // remainder takes the dividend's sign
  logic [WIDTH-1:0]   mcand;     // multiplicand magnitude, or divisor magnitude
  logic [WIDTH-1:0]   rem;       // running remainder (always below the divisor)
  logic [2*WIDTH-1:0] acc;       // MUL: {partial product, multiplier}; DIV: quotient in low half

  logic               aNeg;
  logic               bNeg;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;  // W+1-bit partial remainder for this iteration
  logic [WIDTH:0]     divDiff;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  // Operand magnitudes, one iteration step of each datapath, and the sign fix-up.
  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    aNeg     = ~op[0] & a[WIDTH-1];
    bNeg     = ~op[0] & b[WIDTH-1];
    // |most-negative| is 2^(W-1), which still fits the unsigned W-bit magnitude.
    absA     = aNeg ? -a : a;
    absB     = bNeg ? -b : b;
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    divShift = {rem, acc[WIDTH-1]};
    divDiff  = divShift - {1'b0, mcand};
    prodFix  = negRes ? -acc : acc;
    quotFix  = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remFix   = negRem ? -rem : rem;
  end

  // Control FSM and datapath registers; all outputs are registered.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= StIdle;
      iterCnt  <= '0;
      isDiv    <= 1'b0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
      mcand    <= '0;
      rem      <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            if (op[1] && (b == '0)) begin
              // Divide by zero: report immediately, hi/lo keep their old values.
              done     <= 1'b1;
              div_zero <= 1'b1;
              state    <= StDone;
            end else begin
              isDiv   <= op[1];
              negRes  <= aNeg ^ bNeg;
              negRem  <= aNeg;
              acc     <= {{WIDTH{1'b0}}, (op[1] ? absA : absB)};
              mcand   <= op[1] ? absB : absA;
              rem     <= '0;
              iterCnt <= '0;
              busy    <= 1'b1;
              state   <= StRun;
            end
          end
        end

        StRun: begin
          if (isDiv) begin
            // Restoring step: keep the subtraction only if it did not go negative.
            rem              <= divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], ~divDiff[WIDTH]};
          end else begin
            // Shift-add step: add multiplicand if the current multiplier bit is set.
            acc <= {mulSum, acc[WIDTH-1:1]};
          end
          if (iterCnt == LastIter) begin
            state <= StFix;
          end else begin
            iterCnt <= iterCnt + 1'b1;
          end
        end

        StFix: begin
          if (isDiv) begin
            hi <= remFix;
            lo <= quotFix;
          end else begin
            hi <= prodFix[2*WIDTH-1:WIDTH];
            lo <= prodFix[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= StDone;
        end

        StDone: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          state    <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vector table plus hand-written multi-cycle sequences.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;
  localparam logic [1:0] OpDiv   = 2'b10;
  localparam logic [1:0] OpDivu  = 2'b11;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } vecT;

  vecT vecs[12];

  mult_div_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request for one cycle (cycle 0), then scramble the inputs.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clock);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    op    = ~o;
    a     = ~x;
    b     = ~y ^ 32'h5A5A_0001;
  endtask

  // Sample at each falling edge; cycle c is the period after the c-th rising edge.
  task automatic waitDone(input int glitchAt, output int lat, output int busyCnt);
    lat     = -1;
    busyCnt = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      start = (c == glitchAt);
      if (busy) busyCnt++;
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic countDone(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      if (done) n++;
    end
  endtask

  initial begin
    int lat;
    int busyCnt;
    int extra;

    vecs[0]  = '{OpMult,  32'hFFFFFFFB, 32'd3,       32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m5x3"};
    vecs[1]  = '{OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[2]  = '{OpDivu,  32'd100,      32'd7,       32'd2,        32'd14,       "divu_100_7"};
    vecs[3]  = '{OpDiv,   32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
    vecs[4]  = '{OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_minneg_m1"};
    vecs[5]  = '{OpDiv,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7_m2"};
    vecs[6]  = '{OpDiv,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        "div_m8_m3"};
    vecs[7]  = '{OpMult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minneg_sq"};
    vecs[8]  = '{OpMult,  32'h80000000, 32'd1,       32'hFFFFFFFF, 32'h80000000, "mult_minneg_1"};
    vecs[9]  = '{OpMultu, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        "multu_carry"};
    vecs[10] = '{OpDivu,  32'hFFFFFFFF, 32'h10,      32'hF,        32'h0FFFFFFF, "divu_max_16"};
    vecs[11] = '{OpMult,  32'd6,        32'd7,       32'd0,        32'd42,       "mult_6x7"};

    // Reset held together with a start request: reset must win.
    reset = 1'b1;
    start = 1'b1;
    op    = OpMultu;
    a     = 32'd3;
    b     = 32'd4;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz",   div_zero, 0);
    check("rst_hi",   hi, 0);
    check("rst_lo",   lo, 0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("rst_start_ignored", busy, 0);

    // Vector table: results, latency, busy length, single done pulse.
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      waitDone(0, lat, busyCnt);
      check({vecs[i].name, "_lat"},  64'(lat), 64'(W + 2));
      check({vecs[i].name, "_busy"}, 64'(busyCnt), 64'(W + 1));
      check({vecs[i].name, "_hi"},   hi, vecs[i].hi);
      check({vecs[i].name, "_lo"},   lo, vecs[i].lo);
      check({vecs[i].name, "_dz"},   div_zero, 0);
      @(negedge clock);
      check({vecs[i].name, "_pulse"}, done, 0);
    end

    // Divide by zero right after MULT 6*7: done at cycle 1, hi/lo untouched.
    issue(OpDiv, 32'd5, 32'd0);
    waitDone(0, lat, busyCnt);
    check("div0_lat",  64'(lat), 64'd1);
    check("div0_busy", 64'(busyCnt), 64'd0);
    check("div0_dz",   div_zero, 1);
    check("div0_hi",   hi, 32'd0);
    check("div0_lo",   lo, 32'd42);
    @(negedge clock);
    check("div0_dz_pulse", div_zero, 0);
    check("div0_done_pulse", done, 0);

    issue(OpDivu, 32'd0, 32'd0);
    waitDone(0, lat, busyCnt);
    check("divu0_lat", 64'(lat), 64'd1);
    check("divu0_dz",  div_zero, 1);
    check("divu0_lo",  lo, 32'd42);

    // Start pulsed at cycle 10 of a running op, and again on the done cycle.
    issue(OpMultu, 32'd1000, 32'd1000);
    waitDone(10, lat, busyCnt);
    check("glitch_lat", 64'(lat), 64'(W + 2));
    check("glitch_hi",  hi, 32'd0);
    check("glitch_lo",  lo, 32'h000F4240);
    op    = OpMultu;
    a     = 32'd3;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    check("start_on_done_busy", busy, 0);
    countDone(W + 8, extra);
    check("glitch_single_done", 64'(extra), 64'd0);
    check("glitch_lo_hold", lo, 32'h000F4240);

    // Reset at cycle 15 of a running op: everything clears, no done follows.
    issue(OpMultu, 32'd12345, 32'd678);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clock);
      if (c == 15) reset = 1'b1;
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi",   hi, 0);
    check("abort_lo",   lo, 0);
    countDone(W + 8, extra);
    check("abort_no_done", 64'(extra), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
